// File: rtl/instr_sequencer_if.sv
// Program-memory, ALU and debug signals between the sequencer and its surroundings.
interface instr_sequencer_if;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 4;
   localparam int unsigned SEL_W  = 2;

   logic              run;
   logic [ADDR_W-1:0] imem_addr;
   logic [ADDR_W-1:0] imem_data;
   logic [DATA_W-1:0] alu_opcode;
   logic [DATA_W-1:0] alu_ain;
   logic [DATA_W-1:0] alu_bin;
   logic [DATA_W-1:0] alu_out;
   logic              halted;
   logic [SEL_W-1:0]  dbg_sel;
   logic [DATA_W-1:0] dbg_data;

   // Sequencer side
   modport master (
      input  run, imem_data, alu_out, dbg_sel,
      output imem_addr, alu_opcode, alu_ain, alu_bin, halted, dbg_data
   );

   // Program memory / ALU / debug side
   modport slave (
      output run, imem_data, alu_out, dbg_sel,
      input  imem_addr, alu_opcode, alu_ain, alu_bin, halted, dbg_data
   );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/writeback sequencer: 4x4-bit register file, local LDI/MOV/JMP/HLT,
// ADD/SUB issued to the downstream ALU with result written back in WB.
module instr_sequencer (
   input  logic              clock,
   input  logic              reset_n,
   instr_sequencer_if.master bus
);
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 4;
   localparam int unsigned NREGS  = 4;

   localparam logic [DATA_W-1:0] OP_NOP = 4'h0;
   localparam logic [DATA_W-1:0] OP_ADD = 4'h1;
   localparam logic [DATA_W-1:0] OP_SUB = 4'h2;
   localparam logic [DATA_W-1:0] OP_LDI = 4'h5;
   localparam logic [DATA_W-1:0] OP_MOV = 4'h6;
   localparam logic [DATA_W-1:0] OP_JMP = 4'h7;
   localparam logic [DATA_W-1:0] OP_HLT = 4'hF;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_IMM,
      S_EXEC,
      S_WB,
      S_HALT
   } state_t;

   state_t                        state_q,  state_d;
   logic [ADDR_W-1:0]             pc_q,     pc_d;
   logic [ADDR_W-1:0]             ir_q,     ir_d;
   logic [NREGS-1:0][DATA_W-1:0]  rf_q,     rf_d;
   logic [DATA_W-1:0]             alu_op_q, alu_op_d;
   logic [DATA_W-1:0]             ain_q,    ain_d;
   logic [DATA_W-1:0]             bin_q,    bin_d;
   logic                          halted_q, halted_d;

   logic [DATA_W-1:0] ir_op;
   logic [1:0]        ir_rd;
   logic [1:0]        ir_rs;

   assign ir_op = ir_q[7:4];
   assign ir_rd = ir_q[3:2];
   assign ir_rs = ir_q[1:0];

   // State and datapath registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_FETCH;
         pc_q     <= '0;
         ir_q     <= '0;
         rf_q     <= '0;
         alu_op_q <= OP_NOP;
         ain_q    <= '0;
         bin_q    <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         rf_q     <= rf_d;
         alu_op_q <= alu_op_d;
         ain_q    <= ain_d;
         bin_q    <= bin_d;
         halted_q <= halted_d;
      end
   end

   // Next-state and datapath updates per sequencer state
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      rf_d     = rf_q;
      alu_op_d = alu_op_q;
      ain_d    = ain_q;
      bin_d    = bin_q;
      halted_d = halted_q;

      case (state_q)
         S_FETCH: begin
            if (bus.run) begin
               ir_d    = bus.imem_data;
               pc_d    = pc_q + 8'd1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (ir_op)
               OP_ADD, OP_SUB: begin
                  alu_op_d = ir_op;
                  ain_d    = rf_q[ir_rd];
                  bin_d    = rf_q[ir_rs];
                  state_d  = S_EXEC;
               end
               OP_LDI, OP_JMP: state_d = S_IMM;
               OP_MOV: begin
                  rf_d[ir_rd] = rf_q[ir_rs];
                  state_d     = S_FETCH;
               end
               OP_HLT: begin
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_IMM: begin
            // pc already points at the operand byte
            if (ir_op == OP_LDI) begin
               rf_d[ir_rd] = bus.imem_data[3:0];
               pc_d        = pc_q + 8'd1;
            end else begin
               pc_d = bus.imem_data;
            end
            state_d = S_FETCH;
         end
         S_EXEC:  state_d = S_WB;
         S_WB: begin
            rf_d[ir_rd] = bus.alu_out;
            alu_op_d    = OP_NOP;
            state_d     = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   assign bus.imem_addr  = pc_q;
   assign bus.alu_opcode = alu_op_q;
   assign bus.alu_ain    = ain_q;
   assign bus.alu_bin    = bin_q;
   assign bus.halted     = halted_q;
   assign bus.dbg_data   = rf_q[bus.dbg_sel];

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: instruction-level reference model feeds an ALU-issue
// scoreboard; final pc/regs/halted compared after each program run.
module tb_instr_sequencer;
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   instr_sequencer_if bus ();

   instr_sequencer dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Program memory
   logic [7:0] mem [256];
   assign bus.imem_data = mem[bus.imem_addr];

   // ALU stage: registers its result every edge it sees a live opcode
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n)                     bus.alu_out <= 4'h0;
      else if (bus.alu_opcode == 4'h1)  bus.alu_out <= 4'(bus.alu_ain + bus.alu_bin);
      else if (bus.alu_opcode == 4'h2)  bus.alu_out <= 4'(bus.alu_ain - bus.alu_bin);
   end

   int errors = 0;
   int checks = 0;
   int unsigned cyc = 0;
   int unsigned base = 0;
   logic mon_en = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]  op;
      logic [3:0]  a;
      logic [3:0]  b;
      int unsigned at;
   } alu_ev_t;
   alu_ev_t exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare every ALU issue against the scoreboard and its hold time
   logic [3:0] prev_op = 4'h0;
   int hold_n = 0;
   always @(negedge clock) begin
      if (mon_en) begin
         if (bus.alu_opcode != 4'h0 && prev_op == 4'h0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL alu_issue: unexpected opcode 0x%0h, required none", bus.alu_opcode);
            end else begin
               alu_ev_t e;
               e = exp_q.pop_front();
               check("alu_opcode", int'(bus.alu_opcode), int'(e.op));
               check("alu_ain", int'(bus.alu_ain), int'(e.a));
               check("alu_bin", int'(bus.alu_bin), int'(e.b));
               check("alu_issue_cycle", int'(cyc - base), int'(e.at));
            end
            hold_n <= 1;
         end else if (bus.alu_opcode != 4'h0) begin
            hold_n <= hold_n + 1;
         end else if (prev_op != 4'h0) begin
            check("alu_hold_cycles", hold_n, 2);
         end
      end
      prev_op <= bus.alu_opcode;
   end

   // Reference model state
   logic [7:0]  m_pc;
   logic [3:0]  m_regs [4];
   logic        m_halted;
   int unsigned m_cycles;

   // Instruction-level interpreter; pushes expected ALU issues as it goes
   task automatic run_model(input int max_instr);
      m_pc = 8'h00;
      for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
      m_halted = 1'b0;
      m_cycles = 0;
      for (int n = 0; n < max_instr && !m_halted; n++) begin
         logic [7:0] ins;
         logic [3:0] op;
         int rd, rs;
         alu_ev_t e;
         ins = mem[m_pc];
         op  = ins[7:4];
         rd  = int'(ins[3:2]);
         rs  = int'(ins[1:0]);
         m_pc = m_pc + 8'd1;
         case (op)
            4'h1, 4'h2: begin
               e.op = op;
               e.a  = m_regs[rd];
               e.b  = m_regs[rs];
               e.at = m_cycles + 2;
               exp_q.push_back(e);
               m_regs[rd] = (op == 4'h1) ? 4'(e.a + e.b) : 4'(e.a - e.b);
               m_cycles += 4;
            end
            4'h5: begin
               m_regs[rd] = mem[m_pc][3:0];
               m_pc = m_pc + 8'd1;
               m_cycles += 3;
            end
            4'h6: begin
               m_regs[rd] = m_regs[rs];
               m_cycles += 2;
            end
            4'h7: begin
               m_pc = mem[m_pc];
               m_cycles += 3;
            end
            4'hF: begin
               m_halted = 1'b1;
               m_cycles += 2;
            end
            default: m_cycles += 2;
         endcase
      end
   endtask

   task automatic do_reset();
      mon_en  = 1'b0;
      bus.run = 1'b0;
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   task automatic check_regs(input string tag, input logic [3:0] r0, input logic [3:0] r1,
                             input logic [3:0] r2, input logic [3:0] r3);
      logic [3:0] want [4];
      want[0] = r0; want[1] = r1; want[2] = r2; want[3] = r3;
      for (int i = 0; i < 4; i++) begin
         bus.dbg_sel = 2'(i);
         #1 check($sformatf("%s_r%0d", tag, i), int'(bus.dbg_data), int'(want[i]));
      end
   endtask

   // Run the program in mem for the model's cycle budget, then hold and compare
   task automatic trial(input string tag, input int max_instr);
      do_reset();
      run_model(max_instr);
      mon_en = 1'b1;
      @(negedge clock);
      base = cyc;
      bus.run = 1'b1;
      repeat (m_cycles - 1) @(posedge clock);
      #1 check({tag, "_halted_early"}, int'(bus.halted), 0);
      @(posedge clock);
      #1 bus.run = 1'b0;
      check({tag, "_pc_at_end"}, int'(bus.imem_addr), int'(m_pc));
      check({tag, "_halted"}, int'(bus.halted), int'(m_halted));
      repeat (5) @(posedge clock);
      #1 check({tag, "_pc_held"}, int'(bus.imem_addr), int'(m_pc));
      check({tag, "_alu_idle"}, int'(bus.alu_opcode), 0);
      check_regs(tag, m_regs[0], m_regs[1], m_regs[2], m_regs[3]);
      check({tag, "_alu_events_left"}, exp_q.size(), 0);
      mon_en = 1'b0;
      exp_q.delete();
   endtask

   task automatic load_prog_a();
      clear_mem();
      mem[0] = 8'h50; mem[1] = 8'h03; mem[2] = 8'h54; mem[3] = 8'h05;
      mem[4] = 8'h11; mem[5] = 8'hF0;
   endtask

   function automatic logic [7:0] rand_byte();
      int unsigned r;
      logic [3:0] op;
      r = $urandom_range(0, 99);
      if      (r < 20) op = 4'h1;
      else if (r < 35) op = 4'h2;
      else if (r < 55) op = 4'h5;
      else if (r < 70) op = 4'h6;
      else if (r < 78) op = 4'h7;
      else if (r < 82) op = 4'hF;
      else if (r < 90) op = 4'h0;
      else             op = 4'($urandom_range(0, 15));
      return {op, 4'($urandom_range(0, 15))};
   endfunction

   initial begin
      bus.run     = 1'b0;
      bus.dbg_sel = 2'd0;
      clear_mem();

      // Reset state
      do_reset();
      #1;
      check("rst_imem_addr", int'(bus.imem_addr), 0);
      check("rst_alu_opcode", int'(bus.alu_opcode), 0);
      check("rst_alu_ain", int'(bus.alu_ain), 0);
      check("rst_alu_bin", int'(bus.alu_bin), 0);
      check("rst_halted", int'(bus.halted), 0);
      check_regs("rst", 4'h0, 4'h0, 4'h0, 4'h0);

      // LDI r0,3; LDI r1,5; ADD r0,r1; HLT
      load_prog_a();
      trial("prog_a", 10);
      check("prog_a_cycles_model", int'(m_cycles), 12);
      check("prog_a_addr", int'(bus.imem_addr), 8'h06);
      check_regs("prog_a_const", 4'h8, 4'h5, 4'h0, 4'h0);

      // Reset asserted mid-EXEC of the ADD
      load_prog_a();
      do_reset();
      @(negedge clock);
      bus.run = 1'b1;
      repeat (8) @(posedge clock);
      #1 check("midexec_opcode", int'(bus.alu_opcode), 1);
      check("midexec_ain", int'(bus.alu_ain), 3);
      check("midexec_bin", int'(bus.alu_bin), 5);
      reset_n = 1'b0;
      #1;
      check("midrst_addr", int'(bus.imem_addr), 0);
      check("midrst_opcode", int'(bus.alu_opcode), 0);
      check("midrst_halted", int'(bus.halted), 0);
      check_regs("midrst", 4'h0, 4'h0, 4'h0, 4'h0);
      @(negedge clock);
      reset_n = 1'b1;
      #1 check("restart_addr0", int'(bus.imem_addr), 0);
      repeat (3) @(posedge clock);
      #1 check("restart_addr2", int'(bus.imem_addr), 2);
      bus.run = 1'b0;

      // Drop run during EXEC: writeback still lands, then fetch holds
      load_prog_a();
      do_reset();
      @(negedge clock);
      bus.run = 1'b1;
      repeat (8) @(posedge clock);
      #1 bus.run = 1'b0;
      repeat (6) @(posedge clock);
      #1 check("rundrop_addr", int'(bus.imem_addr), 5);
      check("rundrop_halted", int'(bus.halted), 0);
      check_regs("rundrop", 4'h8, 4'h5, 4'h0, 4'h0);
      repeat (5) @(posedge clock);
      #1 check("runhold_addr", int'(bus.imem_addr), 5);
      check_regs("runhold", 4'h8, 4'h5, 4'h0, 4'h0);
      bus.run = 1'b1;
      repeat (2) @(posedge clock);
      #1 check("resume_halted", int'(bus.halted), 1);
      check("resume_addr", int'(bus.imem_addr), 6);
      bus.run = 1'b0;

      // SUB wrap, ADD wrap, MOV, unknown op 0x3C
      clear_mem();
      mem[0] = 8'h50; mem[1] = 8'h03; mem[2] = 8'h54; mem[3] = 8'h05;
      mem[4] = 8'h21; mem[5] = 8'h58; mem[6] = 8'h0F; mem[7] = 8'h5C;
      mem[8] = 8'h02; mem[9] = 8'h1B; mem[10] = 8'h64; mem[11] = 8'h3C;
      mem[12] = 8'hF0;
      trial("prog_b", 20);
      check_regs("prog_b_const", 4'hE, 4'hE, 4'h1, 4'h2);

      // LDI r0,7; MOV r2,r0; HLT
      clear_mem();
      mem[0] = 8'h50; mem[1] = 8'h07; mem[2] = 8'h68; mem[3] = 8'hF0;
      trial("prog_mov", 5);
      check_regs("prog_mov_const", 4'h7, 4'h0, 4'h7, 4'h0);

      // JMP 0xFF then NOP at 0xFF wraps to 0x00
      clear_mem();
      mem[0] = 8'h70; mem[1] = 8'hFF; mem[255] = 8'h00;
      trial("jmp_wrap", 2);
      check("jmp_wrap_addr", int'(bus.imem_addr), 8'h00);

      // JMP 0x10
      clear_mem();
      mem[0] = 8'h70; mem[1] = 8'h10;
      trial("jmp_10", 1);
      check("jmp_10_addr", int'(bus.imem_addr), 8'h10);

      // LDI at 0xFE whose operand sits at 0xFF
      clear_mem();
      mem[0] = 8'h70; mem[1] = 8'hFE; mem[254] = 8'h54; mem[255] = 8'h09;
      trial("ldi_wrap", 2);
      check("ldi_wrap_addr", int'(bus.imem_addr), 8'h00);
      check_regs("ldi_wrap_const", 4'h0, 4'h9, 4'h0, 4'h0);

      // Randomised programs
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < 256; i++) mem[i] = rand_byte();
         trial($sformatf("rand%0d", t), int'($urandom_range(8, 40)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
